// File: rtl/acc_dump.sv
// acc_dump: captures prompt I/Q at each code-period dump into an epoch-tagged
// first-word-fall-through FIFO with sticky overflow, read over valid/ready.
module acc_dump #(
  parameter int ACC_WIDTH   = 20,
  parameter int EPOCH_WIDTH = 16,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dump,
  input  logic [ACC_WIDTH-1:0]       accumulator_i,
  input  logic [ACC_WIDTH-1:0]       accumulator_q,
  input  logic                       flush,
  input  logic                       clear_overflow,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [ACC_WIDTH-1:0]       out_i,
  output logic [ACC_WIDTH-1:0]       out_q,
  output logic [EPOCH_WIDTH-1:0]     out_epoch,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [ACC_WIDTH-1:0]   r_mem_i [DEPTH];
  logic [ACC_WIDTH-1:0]   r_mem_q [DEPTH];
  logic [EPOCH_WIDTH-1:0] r_mem_e [DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [AW:0]            r_count;
  logic [EPOCH_WIDTH-1:0] r_epoch;
  logic                   r_overflow;
  logic [ACC_WIDTH-1:0]   r_hold_i, r_hold_q;
  logic [EPOCH_WIDTH-1:0] r_hold_e;
  logic                   w_valid, w_full, w_pop, w_push, w_drop;

  assign w_valid = r_count != '0;
  assign w_full  = r_count == (AW+1)'(DEPTH);
  assign w_pop   = w_valid & out_ready;
  assign w_push  = dump & (~w_full | w_pop);
  // A dump discarded by flush is not an overflow drop.
  assign w_drop  = dump & w_full & ~w_pop & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_epoch    <= '0;
      r_overflow <= 1'b0;
      r_hold_i   <= '0;
      r_hold_q   <= '0;
      r_hold_e   <= '0;
    end else begin
      if (dump) r_epoch <= r_epoch + EPOCH_WIDTH'(1);
      r_overflow <= w_drop | (r_overflow & ~clear_overflow);
      // Remember the presented head so outputs hold once the FIFO drains.
      if (w_valid) begin
        r_hold_i <= r_mem_i[r_rd_ptr];
        r_hold_q <= r_mem_q[r_rd_ptr];
        r_hold_e <= r_mem_e[r_rd_ptr];
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem_i[r_wr_ptr] <= accumulator_i;
      r_mem_q[r_wr_ptr] <= accumulator_q;
      r_mem_e[r_wr_ptr] <= r_epoch;
    end
  end

  assign out_valid = w_valid;
  assign out_i     = w_valid ? r_mem_i[r_rd_ptr] : r_hold_i;
  assign out_q     = w_valid ? r_mem_q[r_rd_ptr] : r_hold_q;
  assign out_epoch = w_valid ? r_mem_e[r_rd_ptr] : r_hold_e;
  assign count     = r_count;
  assign overflow  = r_overflow;
endmodule

// File: tb/tb_acc_dump.sv
// tb_acc_dump: table vectors, corner sequences and random traffic against a queue model.
module tb_acc_dump;
  localparam int AW = 20, EW = 4, D = 4;

  logic          clk = 0, reset = 0, dump = 0, flush = 0, clear_overflow = 0, out_ready = 0;
  logic [AW-1:0] accumulator_i = '0, accumulator_q = '0, out_i, out_q;
  logic [EW-1:0] out_epoch;
  logic [2:0]    count;
  logic          out_valid, overflow;

  acc_dump #(.ACC_WIDTH(AW), .EPOCH_WIDTH(EW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .dump(dump), .accumulator_i(accumulator_i),
    .accumulator_q(accumulator_q), .flush(flush), .clear_overflow(clear_overflow),
    .out_ready(out_ready), .out_valid(out_valid), .out_i(out_i), .out_q(out_q),
    .out_epoch(out_epoch), .count(count), .overflow(overflow));

  always #5 clk = ~clk;

  typedef struct { logic [EW-1:0] e; logic [AW-1:0] i, q; } ent_t;
  typedef struct { bit d, fl, clr, rdy; logic [AW-1:0] ai, aq; bit ev; int ec; bit eo; int ee; } vec_t;

  ent_t          mq[$];
  int            m_epoch;
  bit            m_ovf;
  logic [AW-1:0] m_last_i, m_last_q;
  logic [EW-1:0] m_last_e;
  int            n_tests = 0, n_fail = 0;
  vec_t          tv[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_epoch = 0; m_ovf = 0; m_last_i = '0; m_last_q = '0; m_last_e = '0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".i"}, 32'(out_i), 32'(mq.size() ? mq[0].i : m_last_i));
    chk({tag, ".q"}, 32'(out_q), 32'(mq.size() ? mq[0].q : m_last_q));
    chk({tag, ".epoch"}, 32'(out_epoch), 32'(mq.size() ? mq[0].e : m_last_e));
  endtask

  task automatic cycle(input bit d, input logic [AW-1:0] ai, input logic [AW-1:0] aq,
                       input bit fl, input bit clr, input bit rdy, input string tag);
    ent_t e;
    bit   pop;
    dump = d; accumulator_i = ai; accumulator_q = aq; flush = fl; clear_overflow = clr; out_ready = rdy;
    pop = mq.size() != 0 && rdy;
    if (clr) m_ovf = 0;
    if (fl) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (d) begin
        if (mq.size() < D) begin
          e.e = EW'(m_epoch); e.i = ai; e.q = aq;
          mq.push_back(e);
        end else m_ovf = 1;
      end
    end
    if (d) m_epoch = (m_epoch + 1) % (1 << EW);
    @(posedge clk); #1;
    if (mq.size() != 0) begin m_last_i = mq[0].i; m_last_q = mq[0].q; m_last_e = mq[0].e; end
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 0; dump = 0; flush = 0; clear_overflow = 0; out_ready = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.count", 32'(count), 0);
    chk("rst.ovf", 32'(overflow), 0);
    chk("rst.i", 32'(out_i), 0);
    chk("rst.q", 32'(out_q), 0);
    chk("rst.epoch", 32'(out_epoch), 0);
    reset = 1;
  endtask

  function automatic vec_t mk(bit d, bit fl, bit clr, bit rdy, logic [AW-1:0] ai, logic [AW-1:0] aq,
                              bit ev, int ec, bit eo, int ee);
    vec_t v;
    v.d = d; v.fl = fl; v.clr = clr; v.rdy = rdy; v.ai = ai; v.aq = aq;
    v.ev = ev; v.ec = ec; v.eo = eo; v.ee = ee;
    return v;
  endfunction

  initial begin
    //         d  fl clr rdy ai        aq        valid cnt ovf epoch
    tv[0]  = mk(1, 0, 0, 0, 20'h00123, 20'hFFF01, 1, 1, 0, 0);
    tv[1]  = mk(1, 0, 0, 0, 20'h11111, 20'h22222, 1, 2, 0, 0);
    tv[2]  = mk(1, 0, 0, 0, 20'h33333, 20'h44444, 1, 3, 0, 0);
    tv[3]  = mk(1, 0, 0, 0, 20'h55555, 20'h66666, 1, 4, 0, 0);
    tv[4]  = mk(1, 0, 0, 0, 20'h77777, 20'h88888, 1, 4, 1, 0);
    tv[5]  = mk(0, 0, 1, 0, 20'h0,     20'h0,     1, 4, 0, 0);
    tv[6]  = mk(1, 0, 0, 1, 20'h99999, 20'hAAAAA, 1, 4, 0, 1);
    tv[7]  = mk(1, 0, 1, 0, 20'hBBBBB, 20'hCCCCC, 1, 4, 1, 1);
    tv[8]  = mk(1, 1, 0, 0, 20'hDDDDD, 20'hEEEEE, 0, 0, 1, 1);
    tv[9]  = mk(1, 0, 0, 0, 20'h80000, 20'h7FFFF, 1, 1, 1, 8);
    tv[10] = mk(0, 0, 0, 1, 20'h0,     20'h0,     0, 0, 1, 8);

    do_reset();
    for (int k = 0; k < 11; k++) begin
      cycle(tv[k].d, tv[k].ai, tv[k].aq, tv[k].fl, tv[k].clr, tv[k].rdy, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d.tvalid", k), 32'(out_valid), 32'(tv[k].ev));
      chk($sformatf("vec%0d.tcount", k), 32'(count), 32'(tv[k].ec));
      chk($sformatf("vec%0d.tovf", k), 32'(overflow), 32'(tv[k].eo));
      chk($sformatf("vec%0d.tepoch", k), 32'(out_epoch), 32'(tv[k].ee));
      if (k == 0) begin
        chk("single.i", 32'(out_i), 32'h00123);
        chk("single.q", 32'(out_q), 32'hFFF01);
      end
    end

    // Drain the one left after row 10 is already gone; pop the full FIFO's tail order.
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1, AW'(k), AW'(~k), 0, 0, 0, "fill");
    for (int k = 0; k < 4; k++) begin
      chk("fill.order", 32'(out_epoch), 32'(k));
      cycle(0, '0, '0, 0, 0, 1, "drain");
    end
    cycle(1, 20'h12345, 20'h54321, 0, 0, 0, "post5");
    chk("fill.epoch5", 32'(out_epoch), 5);

    // Asynchronous reset between edges.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1, AW'(k + 7), AW'(k + 9), 0, 0, 0, "pre_async");
    chk("async.pre_count", 32'(count), 3);
    #3 reset = 0;
    #1;
    chk("async.valid", 32'(out_valid), 0);
    chk("async.count", 32'(count), 0);
    chk("async.epoch", 32'(out_epoch), 0);
    model_reset();
    @(posedge clk); #1 reset = 1;
    cycle(1, 20'hABCDE, 20'h13579, 0, 0, 0, "after_async");
    chk("async.first_epoch", 32'(out_epoch), 0);

    // Epoch wrap with continuous draining.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      cycle(1, AW'($urandom), AW'($urandom), 0, 0, 1, "wrap");
      chk($sformatf("wrap%0d.epoch", k), 32'(out_epoch), 32'(k % 16));
      chk($sformatf("wrap%0d.ovf", k), 32'(overflow), 0);
    end

    // Random traffic.
    for (int k = 0; k < 3000; k++)
      cycle($urandom_range(0, 99) < 55, AW'($urandom), AW'($urandom),
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6,
            $urandom_range(0, 99) < 40, "rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
